// File: rtl/stm1_rx_deframer.sv
// STM-1 receive deframer: locks to the A1/A2 framing word, tracks row/column
// and extracts the VC-4 J1 byte and the C4 payload (fixed AU pointer).
module stm1_rx_deframer #(
  parameter int unsigned  STM1_LENGTH = 270,
  parameter int unsigned  STM1_WIDTH  = 9,
  parameter int unsigned  POH_COL     = 9,
  parameter logic [7:0]   A1_BYTE     = 8'hF6,
  parameter logic [7:0]   A2_BYTE     = 8'h28,
  parameter int unsigned  MISS_LIMIT  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       out_valid,
  output logic [7:0] out_data,
  output logic [3:0] out_row,
  output logic [8:0] out_col,
  output logic       out_sof,
  output logic [7:0] j1_byte,
  output logic       in_frame,
  output logic       oof
);

  localparam int unsigned MISS_W = $clog2(MISS_LIMIT + 1);

  localparam logic [47:0]       FRAME_WORD = {A1_BYTE, A1_BYTE, A1_BYTE,
                                              A2_BYTE, A2_BYTE, A2_BYTE};
  localparam logic [8:0]        LAST_COL   = 9'(STM1_LENGTH - 1);
  localparam logic [3:0]        LAST_ROW   = 4'(STM1_WIDTH - 1);
  localparam logic [8:0]        CHECK_COL  = 9'd5;
  localparam logic [8:0]        AFTER_WORD = 9'd6;
  localparam logic [8:0]        J1_COL     = 9'(POH_COL);
  localparam logic [8:0]        C4_FIRST   = 9'(POH_COL + 1);
  localparam logic [MISS_W-1:0] MISS_MAX   = MISS_W'(MISS_LIMIT - 1);

  typedef enum logic [1:0] {
    HUNT,
    PRESYNC,
    SYNC
  } state_e;

  state_e            state_q;
  logic [MISS_W-1:0] miss_q;
  logic [3:0]        row_q;
  logic [8:0]        col_q;
  logic [3:0]        row_d;
  logic [8:0]        col_d;
  // Only the previous five bytes are kept: the incoming byte completes the word.
  logic [39:0]       hist_q;
  logic              match;
  logic              at_check;

  logic              out_valid_q;
  logic [7:0]        out_data_q;
  logic [3:0]        out_row_q;
  logic [8:0]        out_col_q;
  logic              out_sof_q;
  logic [7:0]        j1_q;
  logic              in_frame_q;
  logic              oof_q;

  always_comb begin
    match    = ({hist_q, in_data} == FRAME_WORD);
    at_check = (row_q == '0) && (col_q == CHECK_COL);
  end

  always_comb begin
    col_d = col_q + 9'd1;
    row_d = row_q;
    if (col_q == LAST_COL) begin
      col_d = '0;
      row_d = (row_q == LAST_ROW) ? '0 : row_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= HUNT;
      miss_q      <= '0;
      row_q       <= '0;
      col_q       <= '0;
      hist_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_row_q   <= '0;
      out_col_q   <= '0;
      out_sof_q   <= 1'b0;
      j1_q        <= '0;
      in_frame_q  <= 1'b0;
      oof_q       <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      out_sof_q   <= 1'b0;
      oof_q       <= 1'b0;
      if (in_valid) begin
        hist_q <= {hist_q[31:0], in_data};
        case (state_q)
          HUNT: begin
            if (match) begin
              row_q   <= '0;
              col_q   <= AFTER_WORD;
              state_q <= PRESYNC;
            end
          end
          PRESYNC: begin
            row_q <= row_d;
            col_q <= col_d;
            if (at_check) begin
              if (match) begin
                state_q    <= SYNC;
                miss_q     <= '0;
                in_frame_q <= 1'b1;
              end else begin
                state_q <= HUNT;
              end
            end
          end
          SYNC: begin
            row_q <= row_d;
            col_q <= col_d;
            if (at_check) begin
              if (match) begin
                miss_q <= '0;
              end else if (miss_q == MISS_MAX) begin
                state_q    <= HUNT;
                miss_q     <= '0;
                in_frame_q <= 1'b0;
                oof_q      <= 1'b1;
              end else begin
                miss_q <= miss_q + 1'b1;
              end
            end
            if ((row_q == '0) && (col_q == J1_COL)) begin
              j1_q <= in_data;
            end
            if (col_q >= C4_FIRST) begin
              out_valid_q <= 1'b1;
              out_data_q  <= in_data;
              out_row_q   <= row_q;
              out_col_q   <= col_q - C4_FIRST;
              out_sof_q   <= (row_q == '0) && (col_q == C4_FIRST);
            end
          end
          default: state_q <= HUNT;
        endcase
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_row   = out_row_q;
  assign out_col   = out_col_q;
  assign out_sof   = out_sof_q;
  assign j1_byte   = j1_q;
  assign in_frame  = in_frame_q;
  assign oof       = oof_q;

endmodule

// File: tb/tb_stm1_rx_deframer.sv
// Scoreboard bench for stm1_rx_deframer: a frame-offset reference model predicts
// payload, J1, in_frame and oof for randomized and impaired line streams.
module tb_stm1_rx_deframer;

  localparam int LEN   = 270;
  localparam int FRAME = 2430;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = '0;
  logic       out_valid;
  logic [7:0] out_data;
  logic [3:0] out_row;
  logic [8:0] out_col;
  logic       out_sof;
  logic [7:0] j1_byte;
  logic       in_frame;
  logic       oof;

  always #5 clk = ~clk;

  stm1_rx_deframer #(
    .STM1_LENGTH(270),
    .STM1_WIDTH (9),
    .POH_COL    (9),
    .A1_BYTE    (8'hF6),
    .A2_BYTE    (8'h28),
    .MISS_LIMIT (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_row  (out_row),
    .out_col  (out_col),
    .out_sof  (out_sof),
    .j1_byte  (j1_byte),
    .in_frame (in_frame),
    .oof      (oof)
  );

  typedef struct {
    logic [7:0] data;
    int         row;
    int         col;
    bit         sof;
  } exp_t;

  exp_t sbq[$];
  int   errors = 0;
  int   checks = 0;
  int   pop_cnt = 0;
  int   sof_cnt = 0;
  int   oof_cnt = 0;
  bit   mon_en = 1'b0;
  bit   rst_chk = 1'b0;

  // Reference model: lock phase is an absolute byte index, position is offset arithmetic.
  int         m_mode;
  int         m_anchor;
  int         m_n = 0;
  int         m_miss;
  logic [7:0] m_hist[6];
  bit         e_ov, e_oof, e_inf;
  logic [7:0] e_j1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit word_seen();
    return m_hist[0] == 8'hF6 && m_hist[1] == 8'hF6 && m_hist[2] == 8'hF6 &&
           m_hist[3] == 8'h28 && m_hist[4] == 8'h28 && m_hist[5] == 8'h28;
  endfunction

  task automatic model_reset();
    m_mode = 0;
    m_miss = 0;
    for (int i = 0; i < 6; i++) m_hist[i] = 8'h00;
    e_ov  = 1'b0;
    e_oof = 1'b0;
    e_inf = 1'b0;
    e_j1  = 8'h00;
    sbq.delete();
  endtask

  task automatic model_step(input bit v, input logic [7:0] d);
    int   off, row, col;
    bit   hit;
    exp_t e;
    e_ov  = 1'b0;
    e_oof = 1'b0;
    if (!v) return;
    for (int i = 0; i < 5; i++) m_hist[i] = m_hist[i+1];
    m_hist[5] = d;
    hit = word_seen();
    if (m_mode == 0) begin
      if (hit) begin
        m_anchor = m_n;
        m_mode   = 1;
      end
    end else begin
      off = (m_n - m_anchor + 5) % FRAME;
      row = off / LEN;
      col = off % LEN;
      if (m_mode == 1) begin
        if (off == 5) begin
          if (hit) begin
            m_mode = 2;
            m_miss = 0;
            e_inf  = 1'b1;
          end else begin
            m_mode = 0;
          end
        end
      end else begin
        if (off == 5) begin
          if (hit) m_miss = 0;
          else begin
            m_miss++;
            if (m_miss == 4) begin
              m_mode = 0;
              m_miss = 0;
              e_oof  = 1'b1;
              e_inf  = 1'b0;
            end
          end
        end
        if (off == 9) e_j1 = d;
        if (col >= 10) begin
          e.data = d;
          e.row  = row;
          e.col  = col - 10;
          e.sof  = (off == 10);
          sbq.push_back(e);
          e_ov = 1'b1;
        end
      end
    end
    m_n++;
  endtask

  task automatic drive(input bit v, input logic [7:0] d);
    @(negedge clk);
    #1;
    rst      = 1'b0;
    in_valid = v;
    in_data  = d;
    model_step(v, d);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    rst      = 1'b1;
    in_valid = 1'($urandom);
    in_data  = 8'($urandom);
    model_reset();
    rst_chk  = 1'b1;
    mon_en   = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 8'($urandom));
  endtask

  function automatic logic [7:0] fbyte(input int off, input bit corrupt);
    int row, col;
    row = off / LEN;
    col = off % LEN;
    if (off < 3) return 8'hF6;
    if (off < 6) return (corrupt && off == 4) ? 8'h00 : 8'h28;
    if (off == 9) return 8'h5A;
    if (col >= 10) return 8'((row * 260 + col - 10) % 256);
    return 8'h00;
  endfunction

  task automatic send_frame(input bit corrupt, input int gap_pct, input int rst_at);
    for (int off = 0; off < FRAME; off++) begin
      if (off == rst_at) do_reset();
      while (gap_pct > 0 && $urandom_range(99) < gap_pct) drive(1'b0, 8'($urandom));
      drive(1'b1, fbyte(off, corrupt));
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      exp_t e;
      check("out_valid", 32'(out_valid), 32'(e_ov));
      if (out_valid) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL payload_extra: got byte %0h expected no output", out_data);
        end else begin
          e = sbq.pop_front();
          check("out_data", 32'(out_data), 32'(e.data));
          check("out_row", 32'(out_row), 32'(e.row));
          check("out_col", 32'(out_col), 32'(e.col));
          check("out_sof", 32'(out_sof), 32'(e.sof));
          pop_cnt++;
          sof_cnt += int'(out_sof);
        end
      end
      check("in_frame", 32'(in_frame), 32'(e_inf));
      check("oof", 32'(oof), 32'(e_oof));
      check("j1_byte", 32'(j1_byte), 32'(e_j1));
      oof_cnt += int'(oof);
      if (rst_chk) begin
        check("rst_out_data", 32'(out_data), 32'h0);
        check("rst_out_row", 32'(out_row), 32'h0);
        check("rst_out_col", 32'(out_col), 32'h0);
        check("rst_out_sof", 32'(out_sof), 32'h0);
        rst_chk = 1'b0;
      end
    end
  end

  initial begin
    int p0, s0, o0;
    model_reset();

    // Clean lock from reset
    do_reset();
    p0 = pop_cnt; s0 = sof_cnt;
    for (int f = 0; f < 3; f++) send_frame(1'b0, 0, -1);
    idle(2);
    check("p1_payload_count", 32'(pop_cnt - p0), 32'd4680);
    check("p1_sof_count", 32'(sof_cnt - s0), 32'd2);
    check("p1_j1", 32'(j1_byte), 32'h5A);

    // Random garbage with a false framing word, then clean frames
    do_reset();
    p0 = pop_cnt;
    for (int i = 0; i < 1000; i++) begin
      logic [7:0] g;
      g = 8'($urandom);
      if (i >= 400 && i < 403) g = 8'hF6;
      if (i >= 403 && i < 406) g = 8'h28;
      drive(1'b1, g);
    end
    for (int f = 0; f < 4; f++) send_frame(1'b0, 0, -1);
    idle(2);
    check("p2_payload_count", 32'(pop_cnt - p0), 32'd4680);
    check("p2_in_frame", 32'(in_frame), 32'd1);

    // Three bad framing words are tolerated
    p0 = pop_cnt; o0 = oof_cnt;
    for (int f = 0; f < 3; f++) send_frame(1'b1, 0, -1);
    send_frame(1'b0, 0, -1);
    idle(2);
    check("p3_payload_count", 32'(pop_cnt - p0), 32'd9360);
    check("p3_no_oof", 32'(oof_cnt - o0), 32'd0);
    check("p3_in_frame", 32'(in_frame), 32'd1);

    // Four bad framing words lose frame, then relock
    p0 = pop_cnt; o0 = oof_cnt;
    for (int f = 0; f < 4; f++) send_frame(1'b1, 0, -1);
    check("p4_oof_once", 32'(oof_cnt - o0), 32'd1);
    for (int f = 0; f < 3; f++) send_frame(1'b0, 0, -1);
    idle(2);
    check("p4_payload_count", 32'(pop_cnt - p0), 32'd11700);
    check("p4_in_frame", 32'(in_frame), 32'd1);

    // Randomly gapped input
    p0 = pop_cnt; o0 = oof_cnt;
    for (int f = 0; f < 3; f++) send_frame(1'b0, 50, -1);
    idle(2);
    check("p5_payload_count", 32'(pop_cnt - p0), 32'd7020);
    check("p5_no_oof", 32'(oof_cnt - o0), 32'd0);

    // Reset at row 4, col 100 while in frame
    p0 = pop_cnt;
    send_frame(1'b0, 0, 4 * LEN + 100);
    for (int f = 0; f < 3; f++) send_frame(1'b0, 0, -1);
    idle(3);
    check("p6_payload_count", 32'(pop_cnt - p0), 32'd5810);
    check("scoreboard_empty", 32'(sbq.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
